// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending sequencer: state codes, coin codes,
// coin values, the item price table and the greedy change selection.
package vend_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_SELECT   = 3'b001,
        ST_PAY      = 3'b010,
        ST_DISPENSE = 3'b011,
        ST_CHANGE   = 3'b100
    } state_t;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_100 = 2'b11;

    function automatic logic [7:0] coin_val(input logic [1:0] code);
        logic [7:0] v;
        case (code)
            COIN_5:  v = 8'd5;
            COIN_10: v = 8'd10;
            COIN_25: v = 8'd25;
            default: v = 8'd100;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] item_price(input logic [1:0] item);
        logic [7:0] p;
        case (item)
            2'd0:    p = 8'd75;
            2'd1:    p = 8'd100;
            2'd2:    p = 8'd125;
            default: p = 8'd150;
        endcase
        return p;
    endfunction

    // Largest coin not exceeding the amount; amounts are multiples of 5.
    function automatic logic [1:0] greedy_coin(input logic [7:0] amt);
        logic [1:0] c;
        if (amt >= 8'd100)     c = COIN_100;
        else if (amt >= 8'd25) c = COIN_25;
        else if (amt >= 8'd10) c = COIN_10;
        else                   c = COIN_5;
        return c;
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit and price registers: coin add with overflow check, price and
// change subtraction, and greedy selection of the next change coin.
module vend_credit
    import vend_ctrl_pkg::*;
#(
    parameter int CREDIT_MAX = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       price_load,
    input  logic [1:0] sel_item,
    input  logic       coin_add,
    input  logic [1:0] coin_type,
    input  logic       price_sub,
    input  logic       change_sub,
    output logic [7:0] credit,
    output logic [7:0] price,
    output logic       coin_fits,
    output logic       covered,
    output logic [1:0] greedy_code
);

    logic [8:0] credit_sum;
    logic [7:0] change_val;

    // 9-bit sum so a coin that would pass 255 still compares correctly
    assign credit_sum  = {1'b0, credit} + {1'b0, coin_val(coin_type)};
    assign coin_fits   = (credit_sum <= 9'(CREDIT_MAX));
    assign covered     = (credit >= price);
    assign greedy_code = greedy_coin(credit);
    assign change_val  = coin_val(greedy_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit <= '0;
            price  <= '0;
        end else begin
            if (price_load)
                price <= item_price(sel_item);
            if (coin_add)
                credit <= credit_sum[7:0];
            else if (price_sub)
                credit <= credit - price;
            else if (change_sub)
                credit <= credit - change_val;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine sequencer: selection, coin entry with idle timeout,
// timed dispense and greedy change return.
//
// state    | meaning
// IDLE     | waiting for an item selection, coins rejected
// SELECT   | one cycle after selection, arms the idle timer
// PAY      | coin entry until credit covers price, cancel or timeout
// DISPENSE | motor hold for DISPENSE_CYC cycles, price deducted on entry
// CHANGE   | returns remaining credit one coin at a time
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int CREDIT_MAX   = 250,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DISPENSE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    input  logic       change_ready,
    output logic [2:0] state,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       dispense,
    output logic [1:0] dispense_item,
    output logic       change_valid,
    output logic [1:0] change_coin
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int DSP_W = $clog2(DISPENSE_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [DSP_W-1:0] DSP_LOAD = DSP_W'(DISPENSE_CYC - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DSP_W-1:0] dsp_q, dsp_d;
    logic [1:0]       item_q, item_d;
    logic [7:0]       price;
    logic [1:0]       greedy_code;
    logic             coin_fits, covered, first_dsp, credit_zero;
    logic             price_load, coin_add, price_sub, change_sub;

    vend_credit #(
        .CREDIT_MAX(CREDIT_MAX)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .price_load (price_load),
        .sel_item   (sel_item),
        .coin_add   (coin_add),
        .coin_type  (coin_type),
        .price_sub  (price_sub),
        .change_sub (change_sub),
        .credit     (credit),
        .price      (price),
        .coin_fits  (coin_fits),
        .covered    (covered),
        .greedy_code(greedy_code)
    );

    assign state         = state_q;
    assign dispense_item = item_q;
    assign credit_zero   = (credit == 8'd0);
    assign first_dsp     = (state_q == ST_DISPENSE) && (dsp_q == DSP_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            dsp_q   <= '0;
            item_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            dsp_q   <= dsp_d;
            item_q  <= item_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        dsp_d        = dsp_q;
        item_d       = item_q;
        price_load   = 1'b0;
        coin_add     = 1'b0;
        price_sub    = 1'b0;
        change_sub   = 1'b0;
        coin_reject  = 1'b0;
        dispense     = 1'b0;
        change_valid = 1'b0;
        change_coin  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                coin_reject = coin_valid;
                if (sel_valid) begin
                    item_d     = sel_item;
                    price_load = 1'b1;
                    state_d    = ST_SELECT;
                end
            end
            ST_SELECT: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_PAY;
            end
            ST_PAY: begin
                if (coin_valid) begin
                    if (!cancel && coin_fits)
                        coin_add = 1'b1;
                    else
                        coin_reject = 1'b1;
                end
                if (cancel)
                    state_d = ST_CHANGE;
                else if (covered) begin
                    state_d = ST_DISPENSE;
                    dsp_d   = DSP_LOAD;
                end else if (coin_add)
                    tmo_d = TMO_LOAD;
                else if (tmo_q == '0)
                    state_d = ST_CHANGE;
                else
                    tmo_d = tmo_q - TMO_W'(1);
            end
            ST_DISPENSE: begin
                coin_reject = coin_valid;
                dispense    = first_dsp;
                price_sub   = first_dsp;
                // With a one-cycle hold the deduction lands on the exit edge
                if (dsp_q == '0)
                    state_d = (first_dsp ? (credit == price) : credit_zero) ? ST_IDLE : ST_CHANGE;
                else
                    dsp_d = dsp_q - DSP_W'(1);
            end
            ST_CHANGE: begin
                coin_reject = coin_valid;
                if (credit_zero)
                    state_d = ST_IDLE;
                else begin
                    change_valid = 1'b1;
                    change_coin  = greedy_code;
                    change_sub   = change_ready;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: expected reject/dispense/change events are
// queued with the stimulus and popped by a negedge monitor.
module tb_vend_ctrl;

    localparam int TIMEOUT_CYC  = 1000;
    localparam int DISPENSE_CYC = 4;
    localparam logic [1:0] K_REJ = 2'd1;
    localparam logic [1:0] K_DSP = 2'd2;
    localparam logic [1:0] K_CHG = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       cancel = 1'b0;
    logic       change_ready = 1'b1;
    logic [2:0] state;
    logic [7:0] credit;
    logic       coin_reject, dispense, change_valid;
    logic [1:0] dispense_item, change_coin;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    vend_ctrl #(
        .CREDIT_MAX  (250),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .DISPENSE_CYC(DISPENSE_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .change_ready (change_ready),
        .state        (state),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .dispense     (dispense),
        .dispense_item(dispense_item),
        .change_valid (change_valid),
        .change_coin  (change_coin)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [1:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input string name, input logic [1:0] kind, input logic [1:0] val);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event kind %0d val %0d, expected none", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                fails++;
                $display("FAIL %s: got kind %0d val %0d, expected kind %0d val %0d",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (coin_reject)
                expect_ev("reject", K_REJ, 2'b00);
            if (dispense)
                expect_ev("dispense", K_DSP, dispense_item);
            if (change_valid && change_ready)
                expect_ev("change", K_CHG, change_coin);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selection strobe, then through SELECT; returns in the first PAY cycle
    task automatic do_sel(input logic [1:0] item);
        sel_valid = 1'b1;
        sel_item  = item;
        tick();
        sel_valid = 1'b0;
        tick();
    endtask

    task automatic do_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_type  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check(name, state, st);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset state", state, 3'b000);
        check("reset credit", credit, 0);
        check("reset dispense", dispense, 0);
        check("reset change_valid", change_valid, 0);
        check("reset coin_reject", coin_reject, 0);
        check("reset dispense_item", dispense_item, 0);
        check("reset change_coin", change_coin, 0);
        reset = 1'b1;
        tick();

        // 1: item1 (100c) paid with four quarters, exact credit
        push(K_DSP, 2'd1);
        do_sel(2'd1);
        check("t1 in pay", state, 3'b010);
        repeat (4) do_coin(2'b10);
        check("t1 credit", credit, 100);
        check("t1 still pay", state, 3'b010);
        tick();
        check("t1 dispense state", state, 3'b011);
        check("t1 dispense pulse", dispense, 1);
        check("t1 item", dispense_item, 1);
        repeat (DISPENSE_CYC) tick();
        check("t1 back idle", state, 3'b000);
        check("t1 credit zero", credit, 0);

        // 2: item0 (75c) paid with 100c, one quarter back
        push(K_DSP, 2'd0);
        push(K_CHG, 2'b10);
        do_sel(2'd0);
        do_coin(2'b11);
        check("t2 credit", credit, 100);
        tick();
        check("t2 dispense state", state, 3'b011);
        repeat (DISPENSE_CYC) tick();
        check("t2 change state", state, 3'b100);
        check("t2 change credit", credit, 25);
        check("t2 change coin", change_coin, 2'b10);
        wait_state(3'b000, 10, "t2 back idle");
        check("t2 credit zero", credit, 0);

        // 3: item3 (150c), third dollar would overflow 250
        push(K_REJ, 2'b00);
        push(K_DSP, 2'd3);
        push(K_CHG, 2'b10);
        push(K_CHG, 2'b10);
        do_sel(2'd3);
        do_coin(2'b11);
        do_coin(2'b11);
        check("t3 credit 200", credit, 200);
        do_coin(2'b11);
        check("t3 credit after reject", credit, 200);
        check("t3 dispense state", state, 3'b011);
        wait_state(3'b100, 10, "t3 reach change");
        check("t3 change credit", credit, 50);
        wait_state(3'b000, 10, "t3 back idle");
        check("t3 credit zero", credit, 0);

        // 4: cancel beats a nickel in the same cycle
        push(K_REJ, 2'b00);
        push(K_CHG, 2'b01);
        do_sel(2'd2);
        do_coin(2'b01);
        check("t4 credit", credit, 10);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'b00;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        check("t4 change state", state, 3'b100);
        check("t4 credit kept", credit, 10);
        wait_state(3'b000, 10, "t4 back idle");
        check("t4 credit zero", credit, 0);

        // 5: idle timeout refunds a nickel, hopper stalls three cycles
        push(K_CHG, 2'b00);
        do_sel(2'd0);
        do_coin(2'b00);
        check("t5 credit", credit, 5);
        change_ready = 1'b0;
        repeat (TIMEOUT_CYC - 1) tick();
        check("t5 still pay", state, 3'b010);
        tick();
        check("t5 timeout change", state, 3'b100);
        for (int i = 0; i < 3; i++) begin
            check("t5 held valid", change_valid, 1);
            check("t5 held coin", change_coin, 2'b00);
            check("t5 held credit", credit, 5);
            tick();
        end
        change_ready = 1'b1;
        tick();
        wait_state(3'b000, 10, "t5 back idle");
        check("t5 credit zero", credit, 0);

        // 6: reset while change of 30c is pending
        change_ready = 1'b0;
        push(K_DSP, 2'd0);
        do_sel(2'd0);
        do_coin(2'b00);
        do_coin(2'b11);
        check("t6 credit 105", credit, 105);
        tick();
        wait_state(3'b100, 10, "t6 reach change");
        check("t6 change credit", credit, 30);
        check("t6 change coin", change_coin, 2'b10);
        reset = 1'b0;
        #1;
        check("t6 reset state", state, 3'b000);
        check("t6 reset credit", credit, 0);
        check("t6 reset change_valid", change_valid, 0);
        tick();
        reset        = 1'b1;
        change_ready = 1'b1;
        push(K_REJ, 2'b00);
        do_coin(2'b00);
        check("t6 idle credit", credit, 0);
        repeat (5) tick();
        check("t6 stays idle", state, 3'b000);
        check("t6 no change", change_valid, 0);

        check("events drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
